// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the MIPS datapath and pipe_hazard_ctrl.
// master: datapath side (supplies hazard inputs, consumes wall controls).
// slave:  controller side (consumes hazard inputs, drives wall controls).
interface pipe_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rs;
  logic        id_uses_rt;
  logic        ex_memToReg;
  logic        ex_regWr;
  logic [4:0]  ex_aw;
  logic        ex_redirect;
  logic        mem_busy;

  logic        pc_en;
  logic        ifid_en;
  logic        ifid_flush;
  logic        idex_en;
  logic        idex_bubble;
  logic        exmem_en;
  logic [1:0]  state;
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memToReg, ex_regWr, ex_aw,
    output ex_redirect, mem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
    input  state, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_memToReg, ex_regWr, ex_aw,
    input  ex_redirect, mem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en,
    output state, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer for the 4-wall MIPS pipeline (IF, ID, EX, MEM).
// Drives PC enable and the enable/flush/bubble controls of the IF/ID, ID/EX and
// EX/MEM walls from load-use hazards, EX redirects and data-memory busy holds.
// Optional performance counters are built when PIPE_CTRL_PERF_EN is defined;
// otherwise stall_cnt and flush_cnt read 0.
module pipe_hazard_ctrl #(
  parameter int unsigned LOAD_STALL_CYCLES = 1,  // 1..7
  parameter int unsigned FLUSH_CYCLES      = 1   // 1..7
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StFlush   = 2'd2,
    StHold    = 2'd3
  } state_e;

  localparam logic [2:0] LoadReload  = 3'(LOAD_STALL_CYCLES - 1);
  localparam logic [2:0] FlushReload = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       luh;
  logic       pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en;

  // Load-use hazard: EX load writes a register ID reads; $0 never hazards.
  always_comb begin
    luh = bus.ex_memToReg & bus.ex_regWr & (bus.ex_aw != 5'd0) &
          ((bus.id_uses_rs & (bus.id_rs == bus.ex_aw)) |
           (bus.id_uses_rt & (bus.id_rt == bus.ex_aw)));
  end

  // State register and down-counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and wall controls; priority mem_busy > ex_redirect > stall.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_bubble = 1'b0;
    exmem_en    = 1'b1;

    if (state_q == StHold) begin
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      if (!bus.mem_busy) state_d = StRun;
    end else if (bus.mem_busy) begin
      // Any pending stall or flush is abandoned; RUN re-evaluates afterwards.
      {pc_en, ifid_en, idex_en, exmem_en} = 4'b0000;
      state_d = StHold;
      cnt_d   = 3'd0;
    end else if (bus.ex_redirect) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        state_d = StFlush;
        cnt_d   = FlushReload;
      end else begin
        state_d = StRun;
      end
    end else if (state_q == StFlush) begin
      ifid_flush = 1'b1;
      if (cnt_q <= 3'd1) state_d = StRun;
      else               cnt_d   = cnt_q - 3'd1;
    end else if ((state_q == StLdStall) || luh) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      if (state_q == StLdStall) begin
        if (cnt_q <= 3'd1) state_d = StRun;
        else               cnt_d   = cnt_q - 3'd1;
      end else if (LOAD_STALL_CYCLES > 1) begin
        state_d = StLdStall;
        cnt_d   = LoadReload;
      end
    end

    // Reset holds every wall frozen with NOP/bubble content.
    if (!rst_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_en     = 1'b0;
      idex_bubble = 1'b1;
      exmem_en    = 1'b0;
    end
  end

  assign bus.pc_en       = pc_en;
  assign bus.ifid_en     = ifid_en;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.idex_en     = idex_en;
  assign bus.idex_bubble = idex_bubble;
  assign bus.exmem_en    = exmem_en;
  assign bus.state       = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_en && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
    if (ifid_flush && (flush_cnt_q != 32'hFFFF_FFFF)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  // Counter registers, cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`else
  assign bus.stall_cnt = 32'd0;
  assign bus.flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: two instances (3/2 and 1/1 cycle
// configurations) share stimulus; a reference model pushes expected outputs
// per cycle and a monitor pops and compares them at the falling edge.
module tb_pipe_hazard_ctrl;
  localparam int unsigned LA = 3, FA = 2;
  localparam int unsigned LB = 1, FB = 1;

  localparam logic [5:0] CtlRun   = 6'b110101;
  localparam logic [5:0] CtlRedir = 6'b111111;
  localparam logic [5:0] CtlStall = 6'b000111;
  localparam logic [5:0] CtlFlush = 6'b111101;
  localparam logic [5:0] CtlZero  = 6'b000000;
  localparam logic [5:0] CtlRst   = 6'b001010;

  typedef struct packed {
    logic [1:0]  state;
    logic [5:0]  ctl;  // pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus_a ();
  pipe_hazard_ctrl_if bus_b ();

  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(LA), .FLUSH_CYCLES(FA)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );
  pipe_hazard_ctrl #(.LOAD_STALL_CYCLES(LB), .FLUSH_CYCLES(FB)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model: stall/flush cycles still owed, and whether we are holding.
  int      m_hold[2];
  int      m_stall_left[2];
  int      m_flush_left[2];
  longint  m_sc[2];
  longint  m_fc[2];

  function automatic exp_t model_step(int k, int lcyc, int fcyc, logic rst, logic busy,
                                      logic redir, logic luh);
    exp_t e;
    int   st;
    if (!rst) begin
      m_hold[k] = 0; m_stall_left[k] = 0; m_flush_left[k] = 0; m_sc[k] = 0; m_fc[k] = 0;
      e.state = 2'd0; e.ctl = CtlRst; e.stall_cnt = '0; e.flush_cnt = '0;
      return e;
    end
`ifdef PIPE_CTRL_PERF_EN
    e.stall_cnt = 32'(m_sc[k]);
    e.flush_cnt = 32'(m_fc[k]);
`else
    e.stall_cnt = '0;
    e.flush_cnt = '0;
`endif
    st = (m_stall_left[k] > 0) ? 1 : (m_flush_left[k] > 0) ? 2 : 0;
    if (m_hold[k] != 0) begin
      st = 3; e.ctl = CtlZero; m_hold[k] = busy ? 1 : 0;
    end else if (busy) begin
      e.ctl = CtlZero; m_hold[k] = 1; m_stall_left[k] = 0; m_flush_left[k] = 0;
    end else if (redir) begin
      e.ctl = CtlRedir; m_flush_left[k] = fcyc - 1; m_stall_left[k] = 0;
    end else if (m_flush_left[k] > 0) begin
      e.ctl = CtlFlush; m_flush_left[k]--;
    end else if (m_stall_left[k] > 0 || luh) begin
      e.ctl = CtlStall;
      if (m_stall_left[k] > 0) m_stall_left[k]--;
      else m_stall_left[k] = lcyc - 1;
    end else begin
      e.ctl = CtlRun;
    end
    e.state = 2'(st);
    if (!e.ctl[5]) m_sc[k]++;
    if (e.ctl[3]) m_fc[k]++;
    return e;
  endfunction

  task automatic drive(logic rst, logic busy, logic redir, logic ld, logic wr,
                       logic [4:0] aw, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt);
    logic luh;
    @(posedge clk);
    #1;
    rst_n = rst;
    bus_a.mem_busy = busy;   bus_b.mem_busy = busy;
    bus_a.ex_redirect = redir; bus_b.ex_redirect = redir;
    bus_a.ex_memToReg = ld;  bus_b.ex_memToReg = ld;
    bus_a.ex_regWr = wr;     bus_b.ex_regWr = wr;
    bus_a.ex_aw = aw;        bus_b.ex_aw = aw;
    bus_a.id_rs = rs;        bus_b.id_rs = rs;
    bus_a.id_rt = rt;        bus_b.id_rt = rt;
    bus_a.id_uses_rs = urs;  bus_b.id_uses_rs = urs;
    bus_a.id_uses_rt = urt;  bus_b.id_uses_rt = urt;
    luh = ld & wr & (aw != 5'd0) & ((urs & (rs == aw)) | (urt & (rt == aw)));
    q_a.push_back(model_step(0, LA, FA, rst, busy, redir, luh));
    q_b.push_back(model_step(1, LB, FB, rst, busy, redir, luh));
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  task automatic check(string name, exp_t act, exp_t exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s t=%0t: got state=%0d ctl=%b sc=%0d fc=%0d, want state=%0d ctl=%b sc=%0d fc=%0d",
                  name, $time, act.state, act.ctl, act.stall_cnt, act.flush_cnt,
                  exp.state, exp.ctl, exp.stall_cnt, exp.flush_cnt);
  endtask

  // Monitor: compare every presented cycle against the queued expectation.
  initial begin
    exp_t e;
    exp_t act;
    forever begin
      @(negedge clk);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        act = {bus_a.state, bus_a.pc_en, bus_a.ifid_en, bus_a.ifid_flush, bus_a.idex_en,
               bus_a.idex_bubble, bus_a.exmem_en, bus_a.stall_cnt, bus_a.flush_cnt};
        check("dut_a", act, e);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        act = {bus_b.state, bus_b.pc_en, bus_b.ifid_en, bus_b.ifid_flush, bus_b.idex_en,
               bus_b.idex_bubble, bus_b.exmem_en, bus_b.stall_cnt, bus_b.flush_cnt};
        check("dut_b", act, e);
      end
    end
  end

  initial begin
    logic busy_r;
    // Reset for 3 cycles, then idle.
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    // Load-use on rs, then on rt, then $0 destination (no hazard).
    drive(1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    idle(4);
    drive(1, 0, 0, 1, 1, 5'd7, 5'd1, 5'd7, 1, 1);
    idle(4);
    drive(1, 0, 0, 1, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    drive(1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd5, 0, 0);
    idle(1);
    // Redirect, then a second redirect during the flush.
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);
    // mem_busy for 4 cycles with a redirect that waits in EX.
    for (int i = 0; i < 4; i++) drive(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(3);
    // Load stall preempted by mem_busy; hazard persists so the stall restarts.
    drive(1, 0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    drive(1, 1, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    drive(1, 1, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    drive(1, 0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    drive(1, 0, 0, 1, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    idle(4);
    // Randomized traffic with a mid-run reset.
    busy_r = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (i == 250) begin
        for (int j = 0; j < 3; j++) drive(0, 0, 0, 1, 1, 5'd1, 5'd1, 5'd1, 1, 1);
      end
      busy_r = busy_r ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      drive(1, busy_r, $urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    idle(3);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (q_a.size() == 0 && q_b.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d/%0d pending, want 0/0", q_a.size(), q_b.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Pipeline sequencer for the 4-wall MIPS pipeline (IF, ID, EX, MEM). It drives the PC enable and the enable, flush and bubble controls on the IF/ID, ID/EX and EX/MEM register walls. It resolves three conditions: load-use hazards, EX-stage control redirects (branch, jump, jr) and data-memory busy stalls. It replaces the constant PC enable and the ad-hoc branch invalidation AND gates.

Parameters:
LOAD_STALL_CYCLES, 1, number of ID stall cycles inserted per load-use hazard (range 1..7)
FLUSH_CYCLES, 1, number of cycles IF/ID is flushed after a redirect (range 1..7)

Ports:
clk  in  1  pipeline clock, rising-edge
rst_n  in  1  asynchronous active-low reset
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
ex_memToReg  in  1  instruction in EX is a load
ex_regWr  in  1  instruction in EX writes the register file
ex_aw  in  5  destination register of the EX instruction
ex_redirect  in  1  EX resolved a taken branch, jump or jr this cycle
mem_busy  in  1  data memory requests a pipeline hold
pc_en  out  1  PC update enable
ifid_en  out  1  IF/ID wall load enable
ifid_flush  out  1  IF/ID wall loads NOP (0x00000000)
idex_en  out  1  ID/EX wall load enable
idex_bubble  out  1  ID/EX wall loads all-zero control (bubble)
exmem_en  out  1  EX/MEM wall load enable
state  out  2  FSM state: 0 RUN, 1 LDSTALL, 2 FLUSH, 3 HOLD
stall_cnt  out  32  stall-cycle counter (optional feature)
flush_cnt  out  32  flush-cycle counter (optional feature)

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- While rst_n = 0:
  - state = RUN; internal down-counter cnt = 0; stall_cnt = flush_cnt = 0.
  - pc_en = ifid_en = idex_en = exmem_en = 0.
  - ifid_flush = idex_bubble = 1.
- Reset release: the pipeline runs on the first rising edge with rst_n = 1.
- Hazard detect (combinational):
  - luh = ex_memToReg & ex_regWr & (ex_aw != 0) & ((id_uses_rs & id_rs == ex_aw) | (id_uses_rt & id_rt == ex_aw)).
  - Register $0 never causes a hazard.
- Priority, highest first: mem_busy > ex_redirect > luh.
- Outputs are combinational from state and the current inputs. Transitions happen on the rising edge of clk.
- RUN:
  - mem_busy: all enables 0, no flush or bubble; next state HOLD.
  - else ex_redirect: pc_en = 1, ifid_en = 1, ifid_flush = 1, idex_en = 1, idex_bubble = 1, exmem_en = 1. If FLUSH_CYCLES > 1, go to FLUSH with cnt = FLUSH_CYCLES-1; otherwise stay in RUN.
  - else luh: pc_en = 0, ifid_en = 0, idex_en = 1, idex_bubble = 1, exmem_en = 1. If LOAD_STALL_CYCLES > 1, go to LDSTALL with cnt = LOAD_STALL_CYCLES-1; otherwise stay in RUN.
  - else: all enables 1, no flush or bubble.
- LDSTALL:
  - Outputs same as the RUN luh case.
  - cnt decrements each cycle; go to RUN when cnt reaches 1.
  - mem_busy preempts: go to HOLD and resume RUN afterwards. The remaining stall is abandoned; the luh check re-runs in RUN.
  - ex_redirect in LDSTALL is handled as in RUN and supersedes the stall.
- FLUSH:
  - pc_en = 1, ifid_en = 1, ifid_flush = 1, idex_en = 1, idex_bubble = 0, exmem_en = 1.
  - cnt decrements; go to RUN when cnt reaches 1.
  - A new ex_redirect reloads cnt = FLUSH_CYCLES-1 and applies RUN redirect outputs.
  - mem_busy goes to HOLD; the flush is abandoned.
- HOLD:
  - All enables 0, no flush or bubble.
  - Stay while mem_busy = 1; return to RUN when mem_busy = 0.
- Simultaneous mem_busy and ex_redirect: the hold wins. The redirect stays asserted in the frozen EX stage and is serviced on the first RUN cycle.
- state encoding is fixed as listed under Ports.

Optional Feature:
- Macro: PIPE_CTRL_PERF_EN.
- When defined:
  - stall_cnt increments on every clk edge with pc_en = 0 and rst_n = 1.
  - flush_cnt increments on every edge with ifid_flush = 1 and rst_n = 1.
  - Both counters saturate at 0xFFFFFFFF and clear on reset.
- When undefined: the counter registers are not built and both ports are tied to 0.

Test Plan:
- Reset low for 3 cycles, mid-run → outputs immediately show pc_en = 0, ifid_flush = 1, idex_bubble = 1, state = 0. On release, state = 0 and all enables = 1.
- Load-use: EX load to $5, ID uses rs = 5, LOAD_STALL_CYCLES = 1 → one cycle with pc_en = 0, idex_bubble = 1. Repeat with LOAD_STALL_CYCLES = 3 → 3 stall cycles and state sequence 0, 1, 1, 0. Destination $0 → no stall.
- Redirect with FLUSH_CYCLES = 2 → ifid_flush = 1 for 2 cycles and idex_bubble = 1 on the first cycle only. Second redirect during FLUSH → counter restarts.
- mem_busy high for 4 cycles, raised in the same cycle as ex_redirect → all enables 0 for 4 cycles (state = 3), then the redirect flush executes.
- mem_busy raised during LDSTALL with 2 cycles left → HOLD, then RUN; luh re-evaluated, stall restarts if the hazard persists.
- With PIPE_CTRL_PERF_EN: run 2 stall cycles, 1 hold cycle and 2 flush cycles → stall_cnt = 3, flush_cnt = 2. Without the macro, both read 0.
